// File: rtl/mem_arb_ctrl_pkg.sv
// Shared types and sizing for the JTAG/core memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W            = 8;
    localparam int DATA_W            = 16;
    localparam int READY_LOW_CYC_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        CORE_ACC,
        CORE_RD,
        JTAG_ACC,
        JTAG_RD,
        JTAG_HOLD
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mem_arb_ctrl_if.sv
// Bus bundle between the requesters/SRAM (master side) and the arbiter (slave side).
interface mem_arb_ctrl_if;
    import mem_arb_pkg::*;

    logic              sel;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic [DATA_W-1:0] rdata;

    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_gnt;
    logic              core_rvalid;
    logic [DATA_W-1:0] core_rdata;

    logic              mem_cs;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output sel, we, addr, wdata, core_req, core_we, core_addr, core_wdata, mem_rdata,
        input  ready, rdata, core_gnt, core_rvalid, core_rdata,
               mem_cs, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  sel, we, addr, wdata, core_req, core_we, core_addr, core_wdata, mem_rdata,
        output ready, rdata, core_gnt, core_rvalid, core_rdata,
               mem_cs, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_ctrl_sync_2ff.sv
// 1-bit two-flop synchronizer, asynchronous active-low reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/mem_arb_ctrl.sv
// Arbitrates a JTAG (TCK-domain) port and a core port onto one synchronous SRAM.
// Define MEM_ARB_RR_EN for round-robin ties; default build gives JTAG fixed priority.
module mem_arb_ctrl
    import mem_arb_pkg::*;
#(
    parameter int READY_LOW_CYC = READY_LOW_CYC_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arb_ctrl_if.slave bus
);

    localparam logic [7:0] LOW_CYC = 8'(READY_LOW_CYC);

    logic sel_s;

    sync_2ff u_sel_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.sel),
        .q     (sel_s)
    );

    state_e            state_q,       state_d;
    logic              ready_q,       ready_d;
    logic [DATA_W-1:0] rdata_q,       rdata_d;
    logic [DATA_W-1:0] core_rdata_q,  core_rdata_d;
    logic              core_gnt_q,    core_gnt_d;
    logic              core_rvalid_q, core_rvalid_d;
    logic              mem_cs_q,      mem_cs_d;
    logic              mem_we_q,      mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q,   mem_wdata_d;
    logic [7:0]        low_cnt_q,     low_cnt_d;
    logic              wait_clr_q,    wait_clr_d;
    logic              jtag_req;
    logic              jtag_wins_tie;

`ifdef MEM_ARB_RR_EN
    // Records who won the last contested IDLE cycle; reset value lets JTAG take the first tie.
    logic              last_jtag_q,   last_jtag_d;
    assign jtag_wins_tie = ~last_jtag_q;
`else
    assign jtag_wins_tie = 1'b1;
`endif

    assign jtag_req = sel_s & ~wait_clr_q;

    always_comb begin
        state_d       = state_q;
        ready_d       = ready_q;
        rdata_d       = rdata_q;
        core_rdata_d  = core_rdata_q;
        core_gnt_d    = 1'b0;
        core_rvalid_d = 1'b0;
        mem_cs_d      = 1'b0;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        low_cnt_d     = ready_q ? low_cnt_q : sat_inc8(low_cnt_q);
        wait_clr_d    = sel_s ? wait_clr_q : 1'b0;
`ifdef MEM_ARB_RR_EN
        last_jtag_d   = last_jtag_q;
`endif

        case (state_q)
            IDLE: begin
                if (jtag_req && (!bus.core_req || jtag_wins_tie)) begin
                    state_d     = JTAG_ACC;
                    mem_cs_d    = 1'b1;
                    mem_we_d    = bus.we;
                    mem_addr_d  = bus.addr;
                    mem_wdata_d = bus.wdata;
                    ready_d     = 1'b0;
                    low_cnt_d   = 8'd0;
`ifdef MEM_ARB_RR_EN
                    if (bus.core_req) last_jtag_d = 1'b1;
`endif
                end else if (bus.core_req) begin
                    state_d     = CORE_ACC;
                    mem_cs_d    = 1'b1;
                    mem_we_d    = bus.core_we;
                    mem_addr_d  = bus.core_addr;
                    mem_wdata_d = bus.core_wdata;
                    core_gnt_d  = 1'b1;
`ifdef MEM_ARB_RR_EN
                    if (jtag_req) last_jtag_d = 1'b0;
`endif
                end
            end
            CORE_ACC: state_d = mem_we_q ? IDLE : CORE_RD;
            CORE_RD: begin
                core_rdata_d  = bus.mem_rdata;
                core_rvalid_d = 1'b1;
                state_d       = IDLE;
            end
            JTAG_ACC: state_d = mem_we_q ? JTAG_HOLD : JTAG_RD;
            JTAG_RD: begin
                rdata_d = bus.mem_rdata;
                state_d = JTAG_HOLD;
            end
            JTAG_HOLD: begin
                // wait_clr blocks re-triggering until the TCK side drops sel.
                if (low_cnt_q >= LOW_CYC) begin
                    ready_d    = 1'b1;
                    wait_clr_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ready_q       <= 1'b1;
            rdata_q       <= '0;
            core_rdata_q  <= '0;
            core_gnt_q    <= 1'b0;
            core_rvalid_q <= 1'b0;
            mem_cs_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            low_cnt_q     <= 8'd0;
            wait_clr_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_jtag_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            ready_q       <= ready_d;
            rdata_q       <= rdata_d;
            core_rdata_q  <= core_rdata_d;
            core_gnt_q    <= core_gnt_d;
            core_rvalid_q <= core_rvalid_d;
            mem_cs_q      <= mem_cs_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            low_cnt_q     <= low_cnt_d;
            wait_clr_q    <= wait_clr_d;
`ifdef MEM_ARB_RR_EN
            last_jtag_q   <= last_jtag_d;
`endif
        end
    end

    assign bus.ready       = ready_q;
    assign bus.rdata       = rdata_q;
    assign bus.core_gnt    = core_gnt_q;
    assign bus.core_rvalid = core_rvalid_q;
    assign bus.core_rdata  = core_rdata_q;
    assign bus.mem_cs      = mem_cs_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Directed self-checking bench for mem_arb_ctrl with a behavioural SRAM (1-cycle read latency).
module tb_mem_arb_ctrl;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    mem_arb_ctrl_if bus();

    mem_arb_ctrl #(.READY_LOW_CYC(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem_arr [0:255];

    always @(posedge clk) begin
        if (bus.mem_cs) begin
            if (bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem_arr[bus.mem_addr];
        end
    end

    task automatic test_reset();
        int act;
        repeat (3) @(negedge clk);
        n_chk++; if (bus.ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", bus.ready); else n_pass++;
        n_chk++; if (bus.rdata !== 16'h0) $display("FAIL reset_rdata: got %h expected 0000", bus.rdata); else n_pass++;
        n_chk++; if (bus.core_rdata !== 16'h0) $display("FAIL reset_core_rdata: got %h expected 0000", bus.core_rdata); else n_pass++;
        n_chk++; if ({bus.core_gnt, bus.core_rvalid, bus.mem_cs} !== 3'b000)
            $display("FAIL reset_pulses: got gnt/rvalid/cs=%b expected 000", {bus.core_gnt, bus.core_rvalid, bus.mem_cs}); else n_pass++;
        n_chk++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 25'h0)
            $display("FAIL reset_mem_cmd: got %h expected 0", {bus.mem_we, bus.mem_addr, bus.mem_wdata}); else n_pass++;
        rst_n = 1'b1;
        act = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.mem_cs || bus.core_gnt || bus.core_rvalid || !bus.ready) act++;
        end
        n_chk++; if (act !== 0) $display("FAIL reset_release_quiet: got %0d active cycles expected 0", act); else n_pass++;
        $display("reset: done");
    endtask

    task automatic test_jtag_write();
        int low = 0, cs = 0, seen = 0, done = 0, extra = 0, rlow = 0;
        logic [24:0] cs_fields = '0;
        @(negedge clk);
        bus.we = 1'b1; bus.addr = 8'h12; bus.wdata = 16'hA5A5; bus.sel = 1'b1;
        for (int i = 0; i < 40 && done == 0; i++) begin
            @(negedge clk);
            if (bus.mem_cs) begin cs++; cs_fields = {bus.mem_we, bus.mem_addr, bus.mem_wdata}; end
            if (!bus.ready) begin seen = 1; low++; end
            else if (seen != 0) done = 1;
        end
        n_chk++; if (done !== 1) $display("FAIL jw_complete: got %0d expected 1 (timeout)", done); else n_pass++;
        n_chk++; if (cs !== 1) $display("FAIL jw_cs_count: got %0d expected 1", cs); else n_pass++;
        n_chk++; if (cs_fields !== {1'b1, 8'h12, 16'hA5A5}) $display("FAIL jw_cmd: got %h expected %h", cs_fields, {1'b1, 8'h12, 16'hA5A5}); else n_pass++;
        // Counter reads 0 in JTAG_ACC and ready rises the cycle after it reaches 8: 9 low cycles.
        n_chk++; if (low !== 9) $display("FAIL jw_ready_low: got %0d cycles expected 9", low); else n_pass++;
        repeat (10) begin
            @(negedge clk);
            if (bus.mem_cs) extra++;
            if (!bus.ready) rlow++;
        end
        n_chk++; if (extra !== 0 || rlow !== 0) $display("FAIL jw_no_retrigger: got cs=%0d low=%0d expected 0/0", extra, rlow); else n_pass++;
        bus.sel = 1'b0; bus.we = 1'b0;
        repeat (4) @(negedge clk);
        $display("jtag_write: addr=12 data=A5A5 low=%0d", low);
    endtask

    task automatic test_jtag_read();
        int seen = 0, done = 0, cs = 0;
        logic [15:0] last_low = '0, at_rise = '0;
        logic [8:0]  cs_fields = '0;
        @(negedge clk);
        bus.we = 1'b0; bus.addr = 8'h12; bus.sel = 1'b1;
        for (int i = 0; i < 40 && done == 0; i++) begin
            @(negedge clk);
            if (bus.mem_cs) begin cs++; cs_fields = {bus.mem_we, bus.mem_addr}; end
            if (!bus.ready) begin seen = 1; last_low = bus.rdata; end
            else if (seen != 0) begin done = 1; at_rise = bus.rdata; end
        end
        n_chk++; if (done !== 1) $display("FAIL jr_complete: got %0d expected 1 (timeout)", done); else n_pass++;
        n_chk++; if (cs !== 1 || cs_fields !== {1'b0, 8'h12}) $display("FAIL jr_cmd: got n=%0d %h expected 1 012", cs, cs_fields); else n_pass++;
        n_chk++; if (last_low !== 16'hA5A5) $display("FAIL jr_rdata_before_ready: got %h expected a5a5", last_low); else n_pass++;
        n_chk++; if (at_rise !== 16'hA5A5) $display("FAIL jr_rdata_at_ready: got %h expected a5a5", at_rise); else n_pass++;
        bus.sel = 1'b0;
        repeat (5) @(negedge clk);
        n_chk++; if (bus.rdata !== 16'hA5A5) $display("FAIL jr_rdata_held: got %h expected a5a5", bus.rdata); else n_pass++;
        $display("jtag_read: addr=12 rdata=%h", at_rise);
    endtask

    task automatic test_core_read();
        int got = 0, t_gnt = -1, t_rv = -1, n_rv = 0;
        logic [25:0] wr_cmd = '0;
        logic [15:0] rv_data = '0;
        @(negedge clk);
        bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 8'h03; bus.core_wdata = 16'h1234;
        for (int i = 0; i < 10 && got == 0; i++) begin
            @(negedge clk);
            if (bus.core_gnt) begin
                got = 1;
                wr_cmd = {bus.mem_cs, bus.mem_we, bus.mem_addr, bus.mem_wdata};
                bus.core_req = 1'b0;
            end
        end
        n_chk++; if (got !== 1) $display("FAIL cw_gnt: got %0d expected 1 (timeout)", got); else n_pass++;
        n_chk++; if (wr_cmd !== {1'b1, 1'b1, 8'h03, 16'h1234}) $display("FAIL cw_cmd: got %h expected %h", wr_cmd, {1'b1, 1'b1, 8'h03, 16'h1234}); else n_pass++;
        repeat (2) @(negedge clk);
        bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 8'h03;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.core_gnt && t_gnt < 0) begin t_gnt = i; bus.core_req = 1'b0; end
            if (bus.core_rvalid) begin n_rv++; if (t_rv < 0) begin t_rv = i; rv_data = bus.core_rdata; end end
        end
        n_chk++; if (t_gnt < 0) $display("FAIL cr_gnt: got none expected one pulse"); else n_pass++;
        n_chk++; if (t_rv !== t_gnt + 2) $display("FAIL cr_rvalid_latency: got %0d expected %0d", t_rv, t_gnt + 2); else n_pass++;
        n_chk++; if (rv_data !== 16'h1234) $display("FAIL cr_rdata: got %h expected 1234", rv_data); else n_pass++;
        n_chk++; if (n_rv !== 1) $display("FAIL cr_rvalid_pulses: got %0d expected 1", n_rv); else n_pass++;
        $display("core_read: addr=03 gnt@%0d rvalid@%0d rdata=%h", t_gnt, t_rv, rv_data);
    endtask

    // exp_first: 1 = JTAG served first, 2 = core served first.
    task automatic test_tie(input int idx, input int exp_first);
        int first = 0, seen = 0, jdone = 0, cdone = 0;
        @(negedge clk);
        bus.sel = 1'b1; bus.we = 1'b0; bus.addr = 8'h12;
        // sel_s becomes visible two edges later; raise core_req to coincide with it.
        repeat (2) @(negedge clk);
        bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 8'h03;
        for (int i = 0; i < 60 && (jdone == 0 || cdone == 0); i++) begin
            @(negedge clk);
            if (bus.mem_cs && first == 0) first = bus.core_gnt ? 2 : 1;
            if (bus.core_gnt) begin cdone = 1; bus.core_req = 1'b0; end
            if (!bus.ready) seen = 1;
            else if (seen != 0) jdone = 1;
        end
        n_chk++; if (jdone !== 1 || cdone !== 1) $display("FAIL tie%0d_both_served: got jtag=%0d core=%0d expected 1/1", idx, jdone, cdone); else n_pass++;
        n_chk++; if (first !== exp_first) $display("FAIL tie%0d_winner: got %0d expected %0d (1=jtag 2=core)", idx, first, exp_first); else n_pass++;
        bus.sel = 1'b0;
        repeat (4) @(negedge clk);
        $display("tie%0d: first=%0d", idx, first);
    endtask

    task automatic test_back_to_back();
        int seen = 0, done = 0, ng = 0, bad = 0, jcs = 0, rlow = 0, extra = 0;
        @(negedge clk);
        bus.sel = 1'b1; bus.we = 1'b0; bus.addr = 8'h12;
        for (int i = 0; i < 40 && done == 0; i++) begin
            @(negedge clk);
            if (!bus.ready) seen = 1;
            else if (seen != 0) done = 1;
        end
        n_chk++; if (done !== 1) $display("FAIL b2b_jtag_prelude: got %0d expected 1 (timeout)", done); else n_pass++;
        bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 8'h00; bus.core_wdata = 16'hC000;
        for (int i = 0; i < 30 && ng < 4; i++) begin
            @(negedge clk);
            if (bus.mem_cs && !bus.core_gnt) jcs++;
            if (!bus.ready) rlow++;
            if (bus.core_gnt) begin
                if (bus.mem_addr !== ng[7:0] || bus.mem_wdata !== (16'hC000 | 16'(ng))) bad++;
                ng++;
                if (ng == 4) bus.core_req = 1'b0;
                else begin bus.core_addr = ng[7:0]; bus.core_wdata = 16'hC000 | 16'(ng); end
            end
        end
        repeat (6) begin
            @(negedge clk);
            if (bus.mem_cs || bus.core_gnt) extra++;
            if (!bus.ready) rlow++;
        end
        n_chk++; if (ng !== 4) $display("FAIL b2b_gnt_count: got %0d expected 4", ng); else n_pass++;
        n_chk++; if (bad !== 0) $display("FAIL b2b_cmd_seq: got %0d bad commands expected 0", bad); else n_pass++;
        n_chk++; if (jcs !== 0 || rlow !== 0) $display("FAIL b2b_jtag_retrigger: got cs=%0d low=%0d expected 0/0", jcs, rlow); else n_pass++;
        n_chk++; if (extra !== 0) $display("FAIL b2b_trailing: got %0d extra accesses expected 0", extra); else n_pass++;
        bus.sel = 1'b0;
        repeat (4) @(negedge clk);
        $display("back_to_back: core writes=%0d", ng);
    endtask

    task automatic test_reset_mid();
        int acc = 0, act = 0;
        @(negedge clk);
        bus.sel = 1'b1; bus.we = 1'b0; bus.addr = 8'h12;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.mem_cs && !bus.ready) begin acc = 1; break; end
        end
        n_chk++; if (acc !== 1) $display("FAIL rm_jtag_acc: got %0d expected 1 (timeout)", acc); else n_pass++;
        @(negedge clk);
        n_chk++; if (bus.ready !== 1'b0) $display("FAIL rm_in_jtag_rd: got ready=%b expected 0", bus.ready); else n_pass++;
        rst_n = 1'b0; bus.sel = 1'b0;
        #1;
        n_chk++; if (bus.ready !== 1'b1 || bus.mem_cs !== 1'b0) $display("FAIL rm_async_clear: got ready=%b cs=%b expected 1/0", bus.ready, bus.mem_cs); else n_pass++;
        n_chk++; if (bus.rdata !== 16'h0) $display("FAIL rm_rdata_clear: got %h expected 0000", bus.rdata); else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.mem_cs || bus.core_gnt || bus.core_rvalid || !bus.ready) act++;
        end
        n_chk++; if (act !== 0) $display("FAIL rm_no_spurious: got %0d active cycles expected 0", act); else n_pass++;
        $display("reset_mid: aborted JTAG read, post-release activity=%0d", act);
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rst_n = 1'b0;
        bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
        bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
        test_reset();
        test_jtag_write();
        test_jtag_read();
        test_core_read();
        test_tie(1, 1);
`ifdef MEM_ARB_RR_EN
        test_tie(2, 2);
`else
        test_tie(2, 1);
`endif
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arb_ctrl.md
MEM_ARB_CTRL -- requirements
Module: mem_arb_ctrl

Interface
REQ-001 Parameter: READY_LOW_CYC, 8, minimum clk cycles ready SHALL stay low per JTAG access (legal 1..255).
REQ-002 Ports SHALL be: clk  in  1  system clock; one clock only; all flops rising-edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 sel  in  1  JTAG-side request level, TCK domain (asynchronous to clk).
REQ-005 we, addr, wdata  in  1/8/16  JTAG-side write flag, address, write data; stable while sel=1.
REQ-006 ready  out  1  JTAG-side handshake, 1=idle/done, 0=busy; rdata  out  16  JTAG read data.
REQ-007 core_req, core_we, core_addr, core_wdata  in  1/1/8/16  core-side request, held until granted.
REQ-008 core_gnt  out  1  one-cycle accept pulse; core_rvalid  out  1  one-cycle read-data pulse; core_rdata  out  16.
REQ-009 mem_cs, mem_we, mem_addr, mem_wdata  out  1/1/8/16  single-port synchronous SRAM command; mem_rdata  in  16, valid cycle after mem_cs & ~mem_we.

Function
REQ-010 sel SHALL pass through a 2-flop synchronizer (sel_s) before any use; we/addr/wdata SHALL be sampled only when sel_s=1.
REQ-011 JTAG request = sel_s & ~jtag_wait_clr; core request = core_req.
REQ-012 FSM states: IDLE, CORE_ACC, CORE_RD, JTAG_ACC, JTAG_RD, JTAG_HOLD; arbitration only in IDLE.
REQ-013 IDLE->CORE_ACC on core grant: mem_cs=1 with core fields, core_gnt=1 that cycle; write -> IDLE next cycle, read -> CORE_RD.
REQ-014 CORE_RD: core_rdata <= mem_rdata; core_rvalid=1 next cycle (2 cycles after core_gnt); state -> IDLE; core_rdata holds until next core read.
REQ-015 IDLE->JTAG_ACC on JTAG grant: mem_cs=1 with JTAG fields, ready=0 from this cycle; read -> JTAG_RD, write -> JTAG_HOLD.
REQ-016 JTAG_RD: rdata <= mem_rdata; -> JTAG_HOLD; rdata SHALL be stable before ready rises and held until next JTAG read.
REQ-017 8-bit low-counter SHALL clear on JTAG_ACC entry, increment each cycle ready=0, saturate at 255.
REQ-018 JTAG_HOLD exits to IDLE when counter >= READY_LOW_CYC; that cycle ready<=1 and jtag_wait_clr<=1.
REQ-019 jtag_wait_clr SHALL clear when sel_s=0; core traffic SHALL be served while jtag_wait_clr=1.
REQ-020 Simultaneous JTAG and core requests in IDLE: winner per REQ-027; loser waits, no drop.
REQ-021 core_gnt and core_rvalid SHALL never assert in the same cycle as a JTAG mem_cs.
REQ-022 ready, core_gnt, core_rvalid, mem_* SHALL be driven from flops (no combinational input-to-output path).

Reset
REQ-023 Reset values: state IDLE, ready=1, rdata=0, core_rdata=0, core_gnt=0, core_rvalid=0, mem_cs=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-024 Reset SHALL clear jtag_wait_clr, low-counter, synchronizer flops (to 0) and arbitration pointer.
REQ-025 Reset mid-access SHALL abort the access; no pending grant or rvalid SHALL emerge after reset release.

Configuration
REQ-026 Macro MEM_ARB_RR_EN SHALL select arbitration policy.
REQ-027 Undefined: fixed priority, JTAG wins ties; defined: round-robin, tie goes to requester not granted last, pointer resets so JTAG wins the first tie.

Structure
REQ-028 Package mem_arb_pkg SHALL hold the FSM state enum, ADDR_W=8, DATA_W=16, and the READY_LOW_CYC default.
REQ-029 One sub-module, sync_2ff (1-bit, async active-low reset to 0), SHALL synchronize sel.

Verification
REQ-030 JTAG write: sel=1, we=1, addr=8'h12, wdata=16'hA5A5 -> one mem_cs cycle with those values; ready low >= 8 cycles then high; no new access until sel=0.
REQ-031 JTAG read of 8'h12 after REQ-030 -> rdata=16'hA5A5 before ready rises; rdata held after sel drops.
REQ-032 Core read: core_req=1, core_we=0, core_addr=8'h03, memory 16'h1234 -> core_gnt at T, core_rvalid at T+2 with core_rdata=16'h1234.
REQ-033 Tie: sel_s and core_req rise same cycle -> JTAG first (both builds); second tie -> core first only with MEM_ARB_RR_EN.
REQ-034 Core back-to-back writes 8'h00..8'h03 while jtag_wait_clr=1 -> four core_gnt pulses, no JTAG re-trigger.
REQ-035 rst_n low during JTAG_RD -> ready=1, mem_cs=0 immediately; after release with sel=0, no spurious mem_cs, core_gnt or core_rvalid.
